pc_stack: RTL and testbench



---
 rtl/pc_stack.sv | 121 ++++++++++++
 tb/tb_pc_stack.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack for the CR16 fetch path.
// Optional macro PC_STACK_WRAP_EN makes a CALL on a full stack overwrite the oldest entry.
module pc_stack #(
  parameter int P_ADDRESS_WIDTH = 16,
  parameter int P_STACK_DEPTH   = 8,
  parameter int P_RESET_VECTOR  = 0
) (
  input  logic                                     I_CLK,
  input  logic                                     I_RESET,
  input  logic                                     I_ENABLE,
  input  logic [2:0]                               I_MODE,
  input  logic [P_ADDRESS_WIDTH-1:0]               I_ADDRESS,
  input  logic                                     I_ERROR_CLEAR,
  output logic [P_ADDRESS_WIDTH-1:0]               O_ADDRESS,
  output logic [P_ADDRESS_WIDTH-1:0]               O_STACK_TOP,
  output logic [$clog2(P_STACK_DEPTH+1)-1:0]       O_STACK_COUNT,
  output logic                                     O_STACK_FULL,
  output logic                                     O_STACK_EMPTY,
  output logic                                     O_ERROR
);

  localparam int AW = P_ADDRESS_WIDTH;
  localparam int CW = $clog2(P_STACK_DEPTH + 1);
  localparam int PW = $clog2(P_STACK_DEPTH);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(P_STACK_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(P_STACK_DEPTH);

  typedef enum logic [2:0] {
    MODE_INC   = 3'b000,
    MODE_JMP   = 3'b001,
    MODE_JMP1  = 3'b010,
    MODE_REL   = 3'b011,
    MODE_CALL  = 3'b100,
    MODE_RET   = 3'b101,
    MODE_HOLD0 = 3'b110,
    MODE_HOLD1 = 3'b111
  } mode_t;

  logic [AW-1:0] stack_mem [P_STACK_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [CW-1:0] count;
  logic [AW-1:0] top_value;
  logic [AW-1:0] next_pc;
  logic          push;
  logic          pop;
  logic          set_error;
  mode_t         mode;

  assign mode = mode_t'(I_MODE);

  // wr_ptr names the next free slot; pointer arithmetic wraps at the array depth
  assign ptr_inc   = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
  assign ptr_dec   = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PW'(1);
  assign top_value = stack_mem[ptr_dec];

  assign O_STACK_COUNT = count;
  assign O_STACK_FULL  = (count == CNT_FULL);
  assign O_STACK_EMPTY = (count == '0);
  assign O_STACK_TOP   = O_STACK_EMPTY ? '0 : top_value;

  always_comb begin
    next_pc   = O_ADDRESS;
    push      = 1'b0;
    pop       = 1'b0;
    set_error = 1'b0;
    case (mode)
      MODE_INC:  next_pc = O_ADDRESS + ONE;
      MODE_JMP:  next_pc = I_ADDRESS;
      MODE_JMP1: next_pc = I_ADDRESS + ONE;
      MODE_REL:  next_pc = O_ADDRESS + I_ADDRESS;
      MODE_CALL: begin
        next_pc = I_ADDRESS;
`ifdef PC_STACK_WRAP_EN
        push = 1'b1;
`else
        push      = !O_STACK_FULL;
        set_error = O_STACK_FULL;
`endif
      end
      MODE_RET: begin
        // An empty stack degrades RET to INC and flags the underflow
        if (O_STACK_EMPTY) begin
          next_pc   = O_ADDRESS + ONE;
          set_error = 1'b1;
        end else begin
          next_pc = top_value;
          pop     = 1'b1;
        end
      end
      default: next_pc = O_ADDRESS;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_ADDRESS <= AW'(P_RESET_VECTOR);
      wr_ptr    <= '0;
      count     <= '0;
      O_ERROR   <= 1'b0;
    end else begin
      if (I_ENABLE) begin
        O_ADDRESS <= next_pc;
        if (push) begin
          stack_mem[wr_ptr] <= O_ADDRESS + ONE;
          wr_ptr            <= ptr_inc;
          if (!O_STACK_FULL) count <= count + CW'(1);
        end else if (pop) begin
          wr_ptr <= ptr_dec;
          count  <= count - CW'(1);
        end
      end
      // A new error event takes precedence over a simultaneous clear
      if (I_ENABLE && set_error)  O_ERROR <= 1'b1;
      else if (I_ERROR_CLEAR)     O_ERROR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: expected snapshots are queued as stimulus is applied
// and compared against the sampled DUT outputs at the end of each scenario.
module tb_pc_stack;

  localparam int AW = 16;
  localparam int DEPTH = 8;
  localparam logic [15:0] RV = 16'h0100;

  localparam logic [2:0] M_INC  = 3'b000;
  localparam logic [2:0] M_JMP  = 3'b001;
  localparam logic [2:0] M_JMP1 = 3'b010;
  localparam logic [2:0] M_REL  = 3'b011;
  localparam logic [2:0] M_CALL = 3'b100;
  localparam logic [2:0] M_RET  = 3'b101;
  localparam logic [2:0] M_STALL = 3'b110;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] top;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        err;
  } snap_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    mode;
  logic [AW-1:0] address;
  logic          error_clear;
  logic [AW-1:0] o_address;
  logic [AW-1:0] o_stack_top;
  logic [3:0]    o_stack_count;
  logic          o_stack_full;
  logic          o_stack_empty;
  logic          o_error;

  snap_t exp_q[$];
  snap_t obs_q[$];
  int    checks = 0;
  int    errors = 0;

  pc_stack #(
    .P_ADDRESS_WIDTH(AW),
    .P_STACK_DEPTH(DEPTH),
    .P_RESET_VECTOR(RV)
  ) dut (
    .I_CLK(clk),
    .I_RESET(reset),
    .I_ENABLE(enable),
    .I_MODE(mode),
    .I_ADDRESS(address),
    .I_ERROR_CLEAR(error_clear),
    .O_ADDRESS(o_address),
    .O_STACK_TOP(o_stack_top),
    .O_STACK_COUNT(o_stack_count),
    .O_STACK_FULL(o_stack_full),
    .O_STACK_EMPTY(o_stack_empty),
    .O_ERROR(o_error)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(logic [15:0] a, logic [15:0] t, int c, logic e);
    snap_t s;
    s.addr  = a;
    s.top   = t;
    s.count = 4'(c);
    s.full  = (c == DEPTH);
    s.empty = (c == 0);
    s.err   = e;
    return s;
  endfunction

  // Drive one cycle of inputs, then record the outputs one step after the edge
  task automatic apply_stimulus(input logic rst, input logic en, input logic [2:0] m,
                                input logic [15:0] a, input logic clr, input snap_t expect_s);
    @(negedge clk);
    reset       = rst;
    enable      = en;
    mode        = m;
    address     = a;
    error_clear = clr;
    exp_q.push_back(expect_s);
    @(posedge clk);
    #1;
    obs_q.push_back({o_address, o_stack_top, o_stack_count, o_stack_full, o_stack_empty, o_error});
  endtask

  task automatic test_reset();
    snap_t e, g;
    apply_stimulus(1, 0, M_INC, 16'h0000, 0, mk(RV, 16'h0000, 0, 0));
    for (int i = 1; i <= 3; i++)
      apply_stimulus(0, 1, M_INC, 16'h0000, 0, mk(RV + 16'(i), 16'h0000, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL test_reset: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_call_ret();
    snap_t e, g;
    apply_stimulus(0, 1, M_JMP,  16'h0010, 0, mk(16'h0010, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_CALL, 16'h0200, 0, mk(16'h0200, 16'h0011, 1, 0));
    apply_stimulus(0, 1, M_INC,  16'h0000, 0, mk(16'h0201, 16'h0011, 1, 0));
    apply_stimulus(0, 1, M_RET,  16'h0000, 0, mk(16'h0011, 16'h0000, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL test_call_ret: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_arith_wrap();
    snap_t e, g;
    apply_stimulus(0, 1, M_JMP,   16'h0005, 0, mk(16'h0005, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_REL,   16'hFFFE, 0, mk(16'h0003, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_JMP,   16'hFFFF, 0, mk(16'hFFFF, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_INC,   16'h0000, 0, mk(16'h0000, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_JMP1,  16'h0020, 0, mk(16'h0021, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_REL,   16'h0003, 0, mk(16'h0024, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_STALL, 16'h0777, 0, mk(16'h0024, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_JMP1,  16'hFFFF, 0, mk(16'h0000, 16'h0000, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL test_arith_wrap: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_overflow();
    snap_t e, g;
    logic [15:0] stack[$];
    logic [15:0] pc;
    logic [15:0] popped;
    logic        err;
    err = 0;
    apply_stimulus(0, 1, M_JMP, 16'h0000, 0, mk(16'h0000, 16'h0000, 0, 0));
    pc = 16'h0000;
    for (int i = 0; i <= DEPTH; i++) begin
      if (stack.size() < DEPTH) begin
        stack.push_back(pc + 16'h0001);
      end else begin
`ifdef PC_STACK_WRAP_EN
        void'(stack.pop_front());
        stack.push_back(pc + 16'h0001);
`else
        err = 1;
`endif
      end
      pc = 16'h1000 + 16'(i);
      apply_stimulus(0, 1, M_CALL, pc, 0, mk(pc, stack[$], stack.size(), err));
    end
    for (int i = 0; i < DEPTH; i++) begin
      popped = stack.pop_back();
      apply_stimulus(0, 1, M_RET, 16'h0000, 0,
                     mk(popped, (stack.size() > 0) ? stack[$] : 16'h0000, stack.size(), err));
    end
    apply_stimulus(0, 0, M_CALL, 16'h0ABC, 1, mk(popped, 16'h0000, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL test_overflow: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_underflow();
    snap_t e, g;
    apply_stimulus(0, 1, M_JMP,  16'h0040, 0, mk(16'h0040, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_RET,  16'h0000, 0, mk(16'h0041, 16'h0000, 0, 1));
    apply_stimulus(0, 0, M_CALL, 16'h0300, 0, mk(16'h0041, 16'h0000, 0, 1));
    apply_stimulus(0, 0, M_INC,  16'h0000, 1, mk(16'h0041, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_RET,  16'h0000, 1, mk(16'h0042, 16'h0000, 0, 1));
    apply_stimulus(0, 1, M_INC,  16'h0000, 1, mk(16'h0043, 16'h0000, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL test_underflow: got %h expected %h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid_call();
    snap_t e, g;
    apply_stimulus(0, 1, M_JMP,  16'h0000, 0, mk(16'h0000, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_CALL, 16'h0010, 0, mk(16'h0010, 16'h0001, 1, 0));
    apply_stimulus(0, 1, M_CALL, 16'h0020, 0, mk(16'h0020, 16'h0011, 2, 0));
    apply_stimulus(0, 1, M_CALL, 16'h0030, 0, mk(16'h0030, 16'h0021, 3, 0));
    apply_stimulus(1, 1, M_CALL, 16'h0050, 0, mk(RV, 16'h0000, 0, 0));
    apply_stimulus(0, 1, M_RET,  16'h0000, 0, mk(RV + 16'h0001, 16'h0000, 0, 1));
    apply_stimulus(1, 0, M_INC,  16'h0000, 0, mk(RV, 16'h0000, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("[TB] FAIL test_reset_mid_call: got %h expected %h", g, e);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    mode        = M_INC;
    address     = '0;
    error_clear = 1'b0;
    test_reset();
    test_call_ret();
    test_arith_wrap();
    test_overflow();
    test_underflow();
    test_reset_mid_call();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
